conv_loop_sequencer: RTL
========================

// Module: conv_loop_sequencer
// PURPOSE
//   Upstream loop-nest sequencer for the conv address controller. After a start pulse it
//   walks every output pixel (r,c) and every kernel tap (i,j) for it, one tuple per cycle.
//   r/c feed the controller's r/c inputs; i/j are exported for its kernel indices.
//   Accumulator-control strobes and the output-buffer write address go to the MAC/output stage.
// PARAMETERS
//   OUT_SIZE  2  output feature-map height = width (1..15)
//   K         3  kernel height = width (1..15)
//   IDX_W     4  width of r/c/i/j index ports; must match controller r/c (4)
//   ADDR_W    8  width of out_addr; OUT_SIZE*OUT_SIZE-1 must fit
// PORTS
//   clock     in   1       rising-edge clock
//   reset     in   1       asynchronous, active-high reset
//   start     in   1       1-cycle request to begin a layer pass; ignored unless IDLE
//   hold      in   1       freeze the sequence (present only with CONV_SEQ_HOLD_EN)
//   r         out  IDX_W   output row index
//   c         out  IDX_W   output column index
//   i         out  IDX_W   kernel row index
//   j         out  IDX_W   kernel column index
//   valid     out  1       r/c/i/j hold a tuple that is issued this cycle
//   acc_clr   out  1       valid tuple is the first tap (i==0,j==0) of pixel (r,c)
//   acc_last  out  1       valid tuple is the last tap (i==K-1,j==K-1) of pixel (r,c)
//   out_addr  out  ADDR_W  r*OUT_SIZE+c; meaningful while acc_last=1
//   busy      out  1       state != IDLE
//   done      out  1       1-cycle pulse after the final tuple
// BEHAVIOUR
//   - Reset (any time, including mid-pass): state=IDLE; r=c=i=j=0; out_addr=0.
//     valid, acc_clr, acc_last, busy and done are 0.
//   - FSM: IDLE -(start)-> RUN -(last tuple issued)-> DONE -> IDLE (unconditional).
//   - Start sampled in IDLE: next edge enters RUN with indices 0, so valid=1 the cycle after start.
//   - start in RUN/DONE: ignored; no restart and no queuing.
//   - Loop order: j innermost, then i, then c, then r outermost. On each issued tuple:
//     j wraps K-1->0 and carries into i; i wraps K-1->0 and carries into c; c wraps
//     OUT_SIZE-1->0 and carries into r. The last tuple is (OUT_SIZE-1,OUT_SIZE-1,K-1,K-1).
//   - Pass length: exactly OUT_SIZE^2*K^2 issued tuples; 36 at the default parameters.
//   - valid = (state==RUN) && !hold (combinational from state and hold).
//   - acc_clr, acc_last and out_addr are decoded from the registered indices and gated by valid.
//   - Issuing the last tuple: next edge -> DONE; indices return to 0. done=1 for that
//     single cycle with valid=0; following edge -> IDLE.
//   - busy=1 in RUN and DONE.
//   - Index arithmetic is unsigned. out_addr = r*OUT_SIZE+c, computed at ADDR_W without truncation.
//   - Degenerate K=1: acc_clr and acc_last are both 1 on every tuple.
//     Degenerate OUT_SIZE=1: only i/j advance.
// CONFIGURATION
//   CONV_SEQ_HOLD_EN defined: hold port exists. hold=1 in RUN keeps r/c/i/j unchanged and
//     forces valid/acc_clr/acc_last to 0; the sequence resumes from the same tuple on the
//     first cycle hold=0. hold has no effect in IDLE or DONE.
//   CONV_SEQ_HOLD_EN undefined: no hold port; internal hold is tied 0; one tuple per RUN cycle.
// STRUCTURE
//   - Shared package conv_pkg: FSM state localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//     and the common IDX_W / ADDR_W constants shared with controller.
//   - One sub-module, wrap_counter (MAX, W; ports inc, clr, count, wrap), instantiated
//     four times in a carry chain j->i->c->r. The FSM and the strobe decode live in the top.
// TESTING
//   1 Reset mid-pass: assert reset at tuple 10 -> all outputs 0 immediately (async), state IDLE;
//     a new start gives a full 36-tuple pass from (0,0,0,0).
//   2 Default pass: start pulse at cycle 0 -> valid cycles 1..36, first tuple (0,0,0,0) with
//     acc_clr=1; tuple 9 is (0,0,2,2) with acc_last=1 and out_addr=0; tuple 36 is (1,1,2,2)
//     with acc_last=1 and out_addr=3; done=1 in cycle 37 only; busy cycles 1..37.
//   3 Strobe count: over one default pass, exactly 4 acc_clr and 4 acc_last pulses.
//     The out_addr sequence on acc_last is 0,1,2,3.
//   4 Start while busy: pulse start at cycle 5 and in the DONE cycle -> the pass stays 36
//     tuples, no second pass begins, and done pulses once.
//   5 Hold (CONV_SEQ_HOLD_EN): hold=1 for 3 cycles at tuple (0,1,1,0) -> valid=0 and indices
//     frozen for 3 cycles, then resume at (0,1,1,0); done arrives 3 cycles later than in test 2.
//   6 Parameter sweep OUT_SIZE=1,K=1: start -> exactly one tuple with acc_clr=acc_last=1 and
//     out_addr=0, then done.

Source files
------------

// File: rtl/conv_loop_sequencer_pkg.sv
// Shared constants and FSM encoding for the conv loop sequencer and the conv address controller.
package conv_pkg;

  localparam int IDX_W  = 4;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/conv_loop_sequencer_if.sv
// Handshake/output bundle of the conv loop sequencer; the hold input exists only with CONV_SEQ_HOLD_EN.
interface conv_loop_sequencer_if #(
  parameter int IDX_W  = conv_pkg::IDX_W,
  parameter int ADDR_W = conv_pkg::ADDR_W
);

  logic              start;
`ifdef CONV_SEQ_HOLD_EN
  logic              hold;
`endif
  logic [IDX_W-1:0]  r;
  logic [IDX_W-1:0]  c;
  logic [IDX_W-1:0]  i;
  logic [IDX_W-1:0]  j;
  logic              valid;
  logic              acc_clr;
  logic              acc_last;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;

`ifdef CONV_SEQ_HOLD_EN
  modport master (input start, hold,
                  output r, c, i, j, valid, acc_clr, acc_last, out_addr, busy, done);
  modport slave  (output start, hold,
                  input r, c, i, j, valid, acc_clr, acc_last, out_addr, busy, done);
`else
  modport master (input start,
                  output r, c, i, j, valid, acc_clr, acc_last, out_addr, busy, done);
  modport slave  (output start,
                  input r, c, i, j, valid, acc_clr, acc_last, out_addr, busy, done);
`endif

endinterface

// File: rtl/conv_loop_sequencer_wrap_counter.sv
// Modulo-(MAX+1) counter stage of the loop-nest carry chain; wrap doubles as carry-out.
module wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // wrap is combinational so a whole carry chain settles within one cycle
  assign wrap = inc && (count == MAX_V);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Loop-nest sequencer: walks (r,c,i,j) one tuple per cycle and decodes accumulator strobes.
// Optional freeze input enabled by defining CONV_SEQ_HOLD_EN.
module conv_loop_sequencer
  import conv_pkg::*;
#(
  parameter int OUT_SIZE = 2,
  parameter int K        = 3,
  parameter int IDX_W    = conv_pkg::IDX_W,
  parameter int ADDR_W   = conv_pkg::ADDR_W
) (
  input logic                   clock,
  input logic                   reset,
  conv_loop_sequencer_if.master bus
);

  localparam logic [IDX_W-1:0]  K_LAST     = IDX_W'(K - 1);
  localparam logic [ADDR_W-1:0] OUT_SIZE_A = ADDR_W'(OUT_SIZE);

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic              hold;
  logic              advance;
  logic              clr_idx;
  logic              j_wrap;
  logic              i_wrap;
  logic              c_wrap;
  logic              r_wrap;
  logic [IDX_W-1:0]  r_q;
  logic [IDX_W-1:0]  c_q;
  logic [IDX_W-1:0]  i_q;
  logic [IDX_W-1:0]  j_q;
  logic              valid_d;
  logic              acc_clr_d;
  logic              acc_last_d;
  logic              busy_d;
  logic              done_d;
  logic [ADDR_W-1:0] out_addr_d;

`ifdef CONV_SEQ_HOLD_EN
  assign hold = bus.hold;
`else
  assign hold = 1'b0;
`endif

  assign advance = (state_q == RUN) && !hold;
  assign clr_idx = (state_q == IDLE);

  // Carry chain j -> i -> c -> r; r_wrap fires exactly on the final tuple of the pass
  wrap_counter #(.MAX(K - 1), .W(IDX_W)) u_j (
    .clock(clock), .reset(reset), .inc(advance), .clr(clr_idx), .count(j_q), .wrap(j_wrap)
  );
  wrap_counter #(.MAX(K - 1), .W(IDX_W)) u_i (
    .clock(clock), .reset(reset), .inc(j_wrap), .clr(clr_idx), .count(i_q), .wrap(i_wrap)
  );
  wrap_counter #(.MAX(OUT_SIZE - 1), .W(IDX_W)) u_c (
    .clock(clock), .reset(reset), .inc(i_wrap), .clr(clr_idx), .count(c_q), .wrap(c_wrap)
  );
  wrap_counter #(.MAX(OUT_SIZE - 1), .W(IDX_W)) u_r (
    .clock(clock), .reset(reset), .inc(c_wrap), .clr(clr_idx), .count(r_q), .wrap(r_wrap)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus strobes; every strobe is qualified by a tuple actually being issued
  always_comb begin
    state_d    = state_q;
    valid_d    = advance;
    acc_clr_d  = 1'b0;
    acc_last_d = 1'b0;
    out_addr_d = '0;
    busy_d     = (state_q != IDLE);
    done_d     = (state_q == DONE);
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (r_wrap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) begin
      acc_clr_d  = (i_q == '0) && (j_q == '0);
      acc_last_d = (i_q == K_LAST) && (j_q == K_LAST);
      out_addr_d = ADDR_W'(r_q) * OUT_SIZE_A + ADDR_W'(c_q);
    end
  end

  assign bus.r        = r_q;
  assign bus.c        = c_q;
  assign bus.i        = i_q;
  assign bus.j        = j_q;
  assign bus.valid    = valid_d;
  assign bus.acc_clr  = acc_clr_d;
  assign bus.acc_last = acc_last_d;
  assign bus.out_addr = out_addr_d;
  assign bus.busy     = busy_d;
  assign bus.done     = done_d;

endmodule
